// File: rtl/cgra_cfg_loader.sv
// -----------------------------------------------------------------------------
// cgra_cfg_loader
//   Configuration sequencer for a CGRA tile's config frame chain. Pulls FH
//   bitstream words of FW bits from a valid/ready stream and, for each word,
//   presents it on cfg_data, then fires the matching cfg_strb line with
//   programmable setup, pulse and hold times. The fabric clear (clr) is held
//   high for the whole load and dropped together with the done pulse.
//
// Ports
//   clk       in   1    single clock, all state rises on it
//   rst       in   1    synchronous, active-high reset
//   start     in   1    begin a load; only looked at while idle
//   s_data    in   FW   bitstream word, frame order 0..FH-1
//   s_valid   in   1    s_data valid
//   s_ready   out  1    word accepted this cycle (decoded from state)
//   cfg_data  out  FW   to tile cfg_datai
//   cfg_strb  out  FH   to tile cfg_strbi, one-hot or zero
//   clr       out  1    to tile CLREND, high while loading
//   busy      out  1    load in progress (through the done cycle)
//   done      out  1    one-cycle pulse after the last frame's hold
// -----------------------------------------------------------------------------
module cgra_cfg_loader #(
    parameter int FW        = 32,
    parameter int FH        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [FW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [FW-1:0] cfg_data,
    output logic [FH-1:0] cfg_strb,
    output logic          clr,
    output logic          busy,
    output logic          done
);

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW     = $clog2(MAX_C + 1);
    localparam int IW     = (FH > 1) ? $clog2(FH) : 1;

    // The shared counter is loaded with (duration - 1) and the phase ends
    // in the cycle it reads zero, so each phase lasts exactly its duration.
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   idx_q;
    logic [FW-1:0]   cfg_data_q;
    logic [FH-1:0]   cfg_strb_q;
    logic            clr_q;
    logic            busy_q;
    logic            done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            cfg_data_q <= '0;
            cfg_strb_q <= '0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        cfg_data_q <= s_data;
                        cnt_q      <= SETUP_LD;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q    <= STROBE;
                        cnt_q      <= PULSE_LD;
                        // Strobe is registered on entry so it is high exactly
                        // for the STROBE cycles.
                        cfg_strb_q <= FH'(1) << idx_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        state_q    <= HOLD;
                        cnt_q      <= HOLD_LD;
                        cfg_strb_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            clr_q   <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // start is not sampled here; a held start begins the
                    // next load from IDLE one cycle later.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready  = (state_q == FETCH);
    assign cfg_data = cfg_data_q;
    assign cfg_strb = cfg_strb_q;
    assign clr      = clr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cgra_cfg_loader
//   Two loader instances: A with unit setup/pulse/hold, B with 2/3/2.
//   A behavioural model (frame-relative cycle offsets) predicts every output of
//   both instances each cycle; directed loads add literal expectations.
// -----------------------------------------------------------------------------
module tb_cgra_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic        s_valid_a, s_valid_b;
    logic        s_ready_a, s_ready_b;
    logic [31:0] s_data_a, s_data_b;
    logic [31:0] cfg_data_a, cfg_data_b;
    logic [1:0]  cfg_strb_a, cfg_strb_b;
    logic        clr_a, clr_b, busy_a, busy_b, done_a, done_b;

    cgra_cfg_loader #(.FW(32), .FH(2), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .cfg_data(cfg_data_a), .cfg_strb(cfg_strb_a),
        .clr(clr_a), .busy(busy_a), .done(done_a)
    );

    cgra_cfg_loader #(.FW(32), .FH(2), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .cfg_data(cfg_data_b), .cfg_strb(cfg_strb_b),
        .clr(clr_b), .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_strb_a = 0, n_strb_b = 0, n_done_a = 0;
    bit chk_en = 1'b0;
    bit en_a = 1'b0, en_b = 1'b0;
    bit hs_a = 1'b0, hs_b = 1'b0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cyc %0d t=%0t): got %h, need %h", nm, cyc, $time, act, exp);
        end
    endtask

    // Word sources: a handshake at a posedge retires the head of the queue.
    always @(posedge clk) begin
        hs_a <= s_valid_a && s_ready_a && !rst;
        hs_b <= s_valid_b && s_ready_b && !rst;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (hs_a) void'(q_a.pop_front());
        if (hs_b) void'(q_b.pop_front());
        s_valid_a = en_a && (q_a.size() != 0);
        s_data_a  = (q_a.size() != 0) ? q_a[0] : 32'h0;
        s_valid_b = en_b && (q_b.size() != 0);
        s_data_b  = (q_b.size() != 0) ? q_b[0] : 32'h0;
        if (cfg_strb_a != 2'b00) n_strb_a++;
        if (cfg_strb_b != 2'b00) n_strb_b++;
        if (done_a) n_done_a++;
    endtask

    // ---------------- behavioural model ----------------
    // A load is a sequence of frames; t counts cycles since the frame's word
    // was accepted: 1..S setup, S+1..S+P strobe, S+P+1..S+P+H hold.
    int S_C[2] = '{1, 2};
    int P_C[2] = '{1, 3};
    int H_C[2] = '{1, 2};

    bit          m_act[2], m_wt[2], m_fin[2];
    int          m_f[2], m_t[2];
    logic [31:0] e_data[2];
    logic [1:0]  e_strb[2];
    bit          e_clr[2], e_busy[2], e_done[2], e_rdy[2];

    bit          ma, mw, mfn, mcl, mbs, mdn, mst, mvl;
    int          mff, mtt;
    logic [31:0] md, mdt;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ma = m_act[i]; mw = m_wt[i]; mfn = m_fin[i]; mff = m_f[i]; mtt = m_t[i];
            md = e_data[i]; mcl = e_clr[i]; mbs = e_busy[i]; mdn = 1'b0;
            mst = (i == 0) ? start_a : start_b;
            mvl = (i == 0) ? s_valid_a : s_valid_b;
            mdt = (i == 0) ? s_data_a : s_data_b;
            if (rst) begin
                ma = 0; mw = 0; mfn = 0; mff = 0; mtt = 0; md = 32'h0; mcl = 0; mbs = 0;
            end else if (mfn) begin
                mfn = 0; mbs = 0;
            end else if (!ma) begin
                if (mst) begin ma = 1; mw = 1; mff = 0; mbs = 1; mcl = 1; end
            end else if (mw) begin
                if (mvl) begin md = mdt; mw = 0; mtt = 1; end
            end else if (mtt == S_C[i] + P_C[i] + H_C[i]) begin
                if (mff == 1) begin ma = 0; mfn = 1; mdn = 1; mcl = 0; end
                else begin mff = mff + 1; mw = 1; end
            end else begin
                mtt = mtt + 1;
            end
            m_act[i]  <= ma;  m_wt[i] <= mw; m_fin[i] <= mfn; m_f[i] <= mff; m_t[i] <= mtt;
            e_data[i] <= md;  e_clr[i] <= mcl; e_busy[i] <= mbs; e_done[i] <= mdn;
            e_rdy[i]  <= ma && mw;
            e_strb[i] <= (ma && !mw && mtt > S_C[i] && mtt <= S_C[i] + P_C[i]) ? 2'(1 << mff) : 2'b00;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.s_ready",  {31'b0, s_ready_a}, {31'b0, e_rdy[0]});
            chk("a.cfg_data", cfg_data_a, e_data[0]);
            chk("a.cfg_strb", {30'b0, cfg_strb_a}, {30'b0, e_strb[0]});
            chk("a.clr",      {31'b0, clr_a},  {31'b0, e_clr[0]});
            chk("a.busy",     {31'b0, busy_a}, {31'b0, e_busy[0]});
            chk("a.done",     {31'b0, done_a}, {31'b0, e_done[0]});
            chk("b.s_ready",  {31'b0, s_ready_b}, {31'b0, e_rdy[1]});
            chk("b.cfg_data", cfg_data_b, e_data[1]);
            chk("b.cfg_strb", {30'b0, cfg_strb_b}, {30'b0, e_strb[1]});
            chk("b.clr",      {31'b0, clr_b},  {31'b0, e_clr[1]});
            chk("b.busy",     {31'b0, busy_b}, {31'b0, e_busy[1]});
            chk("b.done",     {31'b0, done_b}, {31'b0, e_done[1]});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset held two cycles with start and s_valid high.
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        s_valid_a = 1'b1; s_valid_b = 1'b1;
        s_data_a = 32'h5A5A5A5A; s_data_b = 32'hA5A5A5A5;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst.s_ready",  {31'b0, s_ready_a}, 32'd0);
            chk("rst.cfg_strb", {30'b0, cfg_strb_a}, 32'd0);
            chk("rst.cfg_data", cfg_data_a, 32'd0);
            chk("rst.clr",      {31'b0, clr_a}, 32'd0);
            chk("rst.busy",     {31'b0, busy_a}, 32'd0);
            chk("rst.done",     {31'b0, done_a}, 32'd0);
            chk("rst.b_ready",  {31'b0, s_ready_b}, 32'd0);
        end
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        s_valid_a = 1'b0; s_valid_b = 1'b0;
        tick(); tick();

        // Nominal load, words always valid, one extra word left pending.
        q_a.delete();
        q_a.push_back(32'hDEADBEEF); q_a.push_back(32'h12345678); q_a.push_back(32'hCAFEF00D);
        en_a = 1'b1;
        tick(); start_a = 1'b1; cyc = 0; n_strb_a = 0; n_done_a = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(); start_a = 1'b0;
            case (cyc)
                1: begin chk("t2.rdy_c1", {31'b0, s_ready_a}, 32'd1);
                         chk("t2.clr_c1", {31'b0, clr_a}, 32'd1);
                         chk("t2.busy_c1", {31'b0, busy_a}, 32'd1); end
                3: begin chk("t2.strb_c3", {30'b0, cfg_strb_a}, 32'd1);
                         chk("t2.data_c3", cfg_data_a, 32'hDEADBEEF);
                         chk("model.strb_c3", {30'b0, e_strb[0]}, 32'd1); end
                4: chk("t2.strb_c4", {30'b0, cfg_strb_a}, 32'd0);
                5: chk("t2.rdy_c5", {31'b0, s_ready_a}, 32'd1);
                7: begin chk("t2.strb_c7", {30'b0, cfg_strb_a}, 32'd2);
                         chk("t2.data_c7", cfg_data_a, 32'h12345678);
                         chk("model.data_c7", e_data[0], 32'h12345678); end
                8: chk("t2.clr_c8", {31'b0, clr_a}, 32'd1);
                9: begin chk("t2.done_c9", {31'b0, done_a}, 32'd1);
                         chk("t2.clr_c9", {31'b0, clr_a}, 32'd0);
                         chk("model.done_c9", {31'b0, e_done[0]}, 32'd1); end
                10: begin chk("t2.busy_c10", {31'b0, busy_a}, 32'd0);
                          chk("t2.done_c10", {31'b0, done_a}, 32'd0); end
                default: ;
            endcase
        end
        chk("t2.strobes", n_strb_a, 32'd2);
        chk("t2.dones", n_done_a, 32'd1);
        chk("t2.pending", q_a.size(), 32'd1);

        // Stall: no valid for 5 cycles during frame-1 fetch.
        q_a.delete();
        q_a.push_back(32'hDEADBEEF); q_a.push_back(32'h12345678);
        tick(); start_a = 1'b1; cyc = 0;
        for (int k = 1; k <= 15; k++) begin
            en_a = !(k >= 5 && k <= 9);
            tick(); start_a = 1'b0;
            if (k >= 5 && k <= 9) begin
                chk("t3.rdy_stall", {31'b0, s_ready_a}, 32'd1);
                chk("t3.strb_stall", {30'b0, cfg_strb_a}, 32'd0);
                chk("t3.clr_stall", {31'b0, clr_a}, 32'd1);
                chk("t3.data_stall", cfg_data_a, 32'hDEADBEEF);
            end
            if (k == 12) begin
                chk("t3.strb_c12", {30'b0, cfg_strb_a}, 32'd2);
                chk("t3.data_c12", cfg_data_a, 32'h12345678);
            end
            if (k == 13) chk("t3.done_c13", {31'b0, done_a}, 32'd0);
            if (k == 14) chk("t3.done_c14", {31'b0, done_a}, 32'd1);
            if (k == 15) chk("t3.busy_c15", {31'b0, busy_a}, 32'd0);
        end
        en_a = 1'b1;

        // start pulsed mid-load is ignored.
        q_a.delete();
        q_a.push_back(32'hABCD0001); q_a.push_back(32'hABCD0002);
        tick(); start_a = 1'b1; cyc = 0; n_strb_a = 0; n_done_a = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(); start_a = (k == 4);
            if (k == 7) chk("t5.data_c7", cfg_data_a, 32'hABCD0002);
            if (k == 9) chk("t5.done_c9", {31'b0, done_a}, 32'd1);
            if (k == 12) begin
                chk("t5.busy_c12", {31'b0, busy_a}, 32'd0);
                chk("t5.rdy_c12", {31'b0, s_ready_a}, 32'd0);
            end
        end
        chk("t5.strobes", n_strb_a, 32'd2);
        chk("t5.dones", n_done_a, 32'd1);

        // start held through done restarts one cycle after idle.
        q_a.delete();
        q_a.push_back(32'h77770000); q_a.push_back(32'h77770001);
        tick(); start_a = 1'b1; cyc = 0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 9) chk("t7.done_c9", {31'b0, done_a}, 32'd1);
            if (k == 10) begin
                chk("t7.busy_c10", {31'b0, busy_a}, 32'd0);
                chk("t7.rdy_c10", {31'b0, s_ready_a}, 32'd0);
                chk("t7.data_kept", cfg_data_a, 32'h77770001);
            end
            if (k == 11) begin
                chk("t7.rdy_c11", {31'b0, s_ready_a}, 32'd1);
                chk("t7.busy_c11", {31'b0, busy_a}, 32'd1);
                chk("t7.clr_c11", {31'b0, clr_a}, 32'd1);
            end
        end
        start_a = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("t7.busy_after_rst", {31'b0, busy_a}, 32'd0);
        tick();

        // Reset during STROBE, then a clean reload from frame 0.
        q_a.delete();
        q_a.push_back(32'h11111111); q_a.push_back(32'h22222222);
        tick(); start_a = 1'b1; cyc = 0;
        for (int k = 1; k <= 4; k++) begin
            tick(); start_a = 1'b0; rst = (k == 3);
            if (k == 3) chk("t6.strb_c3", {30'b0, cfg_strb_a}, 32'd1);
            if (k == 4) begin
                chk("t6.strb_c4", {30'b0, cfg_strb_a}, 32'd0);
                chk("t6.clr_c4",  {31'b0, clr_a}, 32'd0);
                chk("t6.busy_c4", {31'b0, busy_a}, 32'd0);
                chk("t6.done_c4", {31'b0, done_a}, 32'd0);
            end
        end
        q_a.delete();
        q_a.push_back(32'h33333333); q_a.push_back(32'h44444444);
        tick(); start_a = 1'b1; cyc = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(); start_a = 1'b0;
            if (k == 3) begin
                chk("t6.re_strb_c3", {30'b0, cfg_strb_a}, 32'd1);
                chk("t6.re_data_c3", cfg_data_a, 32'h33333333);
            end
            if (k == 7) begin
                chk("t6.re_strb_c7", {30'b0, cfg_strb_a}, 32'd2);
                chk("t6.re_data_c7", cfg_data_a, 32'h44444444);
            end
            if (k == 9) chk("t6.re_done_c9", {31'b0, done_a}, 32'd1);
        end

        // Timing parameters 2/3/2 on instance B.
        q_b.delete();
        q_b.push_back(32'hAAAA5555); q_b.push_back(32'h0F0F0F0F);
        en_b = 1'b1;
        tick(); start_b = 1'b1; cyc = 0; n_strb_b = 0;
        for (int k = 1; k <= 18; k++) begin
            tick(); start_b = 1'b0;
            if (k == 1 || k == 9) chk("t4.rdy", {31'b0, s_ready_b}, 32'd1);
            if (k inside {2, 3, 7, 8}) begin
                chk("t4.f0_quiet_strb", {30'b0, cfg_strb_b}, 32'd0);
                chk("t4.f0_quiet_data", cfg_data_b, 32'hAAAA5555);
            end
            if (k inside {4, 5, 6}) begin
                chk("t4.f0_strb", {30'b0, cfg_strb_b}, 32'd1);
                chk("t4.f0_data", cfg_data_b, 32'hAAAA5555);
            end
            if (k inside {10, 11, 15, 16}) begin
                chk("t4.f1_quiet_strb", {30'b0, cfg_strb_b}, 32'd0);
                chk("t4.f1_quiet_data", cfg_data_b, 32'h0F0F0F0F);
            end
            if (k inside {12, 13, 14}) begin
                chk("t4.f1_strb", {30'b0, cfg_strb_b}, 32'd2);
                chk("t4.f1_data", cfg_data_b, 32'h0F0F0F0F);
            end
            if (k == 16) chk("t4.done_c16", {31'b0, done_b}, 32'd0);
            if (k == 17) begin
                chk("t4.done_c17", {31'b0, done_b}, 32'd1);
                chk("t4.clr_c17",  {31'b0, clr_b}, 32'd0);
                chk("t4.busy_c17", {31'b0, busy_b}, 32'd1);
                chk("model.b_done_c17", {31'b0, e_done[1]}, 32'd1);
            end
            if (k == 18) chk("t4.busy_c18", {31'b0, busy_b}, 32'd0);
        end
        chk("t4.strobe_cycles", n_strb_b, 32'd6);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
